// File: rtl/spi_pkg.sv
// Shared frame widths, command codes and state/classification types for the
// SPI register-bank back end.
package spi_pkg;
   localparam int CMD_W  = 8;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;

   localparam logic [CMD_W-1:0]  CMD_WR      = 8'h55;
   localparam logic [CMD_W-1:0]  CMD_RD      = 8'h56;
   localparam logic [ADDR_W-1:0] STATUS_ADDR = 24'hFFFFFF;

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;
   typedef enum logic [1:0] {WR_OK, RD_OK, RD_BAD, ERR} cls_t;

   function automatic logic [DATA_W-1:0] status_word(input logic ovr,
                                                     input logic [7:0] err,
                                                     input logic [15:0] wr);
      return {ovr, 7'b0, err, wr};
   endfunction
endpackage

// File: rtl/spi_reg_bank_if.sv
// Frame/response bundle between spi_slave (master side) and the register bank
// (slave side).
interface spi_reg_bank_if;
   import spi_pkg::*;

   logic              frame_valid;
   logic [CMD_W-1:0]  cmd;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] data_miso;
   logic              rd_valid;
   logic              rd_err;
   logic              busy;

   modport master (output frame_valid, cmd, address, data,
                   input  data_miso, rd_valid, rd_err, busy);
   modport slave  (input  frame_valid, cmd, address, data,
                   output data_miso, rd_valid, rd_err, busy);
endinterface

// File: rtl/spi_cmd_decode.sv
// Combinational classification of a latched frame into WR_OK/RD_OK/RD_BAD/ERR.
// Zero latency; no flow control (parent registers the result in DECODE).
module spi_cmd_decode
   import spi_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic [CMD_W-1:0]  cmd,
   input  logic [ADDR_W-1:0] address,
   output cls_t              cls
);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   logic in_range;
   assign in_range = (address < DEPTH_A);

   // A write to STATUS_ADDR falls through to ERR: the status word is read-only.
   always_comb begin
      cls = ERR;
      if (cmd == CMD_WR && in_range)
         cls = WR_OK;
      else if (cmd == CMD_RD)
         cls = (in_range || address == STATUS_ADDR) ? RD_OK : RD_BAD;
   end
endmodule

// File: rtl/spi_reg_bank.sv
// Executes decoded SPI frames against a 32-bit register array plus status word.
// Read data 2 edges after acceptance; frames arriving while busy are dropped and flag overrun.
module spi_reg_bank
   import spi_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic              sclk_m,
   input  logic              reset,
   spi_reg_bank_if.slave     bus,
   output logic [DATA_W-1:0] ctrl_out
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t            state, state_nxt;
   cls_t              dec_cls, cls_q;
   logic [CMD_W-1:0]  cmd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [15:0]       wr_cnt;
   logic [7:0]        err_cnt;
   logic              overrun;
   logic [IDX_W-1:0]  idx;

   assign idx      = addr_q[IDX_W-1:0];
   assign bus.busy = (state != IDLE);

   spi_cmd_decode #(.DEPTH(DEPTH)) u_decode (
      .cmd     (cmd_q),
      .address (addr_q),
      .cls     (dec_cls)
   );

   always_ff @(posedge sclk_m) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.frame_valid) state_nxt = DECODE;
         DECODE:  state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sclk_m) begin
      if (!reset) begin
         cmd_q         <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         cls_q         <= ERR;
         wr_cnt        <= '0;
         err_cnt       <= '0;
         overrun       <= 1'b0;
         bus.data_miso <= '0;
         bus.rd_valid  <= 1'b0;
         bus.rd_err    <= 1'b0;
         ctrl_out      <= '0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         ctrl_out <= regs[0];

         if (state == IDLE && bus.frame_valid) begin
            cmd_q  <= bus.cmd;
            addr_q <= bus.address;
            data_q <= bus.data;
         end

         if (state == DECODE) cls_q <= dec_cls;

         if (state == EXEC) begin
            case (cls_q)
               WR_OK: begin
                  regs[idx] <= data_q;
                  if (wr_cnt != '1) wr_cnt <= wr_cnt + 16'd1;
               end
               RD_OK: begin
                  bus.rd_valid <= 1'b1;
                  bus.rd_err   <= 1'b0;
                  if (addr_q == STATUS_ADDR) begin
                     bus.data_miso <= status_word(overrun, err_cnt, wr_cnt);
                     overrun       <= 1'b0;
                  end else begin
                     bus.data_miso <= regs[idx];
                  end
               end
               RD_BAD: begin
                  bus.data_miso <= '0;
                  bus.rd_valid  <= 1'b1;
                  bus.rd_err    <= 1'b1;
                  if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
               end
               ERR: begin
                  if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
               end
               default: ;
            endcase
         end

         if (state == RESP) bus.rd_valid <= 1'b0;

         // Placed after the status-read clear so a same-edge drop keeps overrun set.
         if (bus.frame_valid && state != IDLE) overrun <= 1'b1;
      end
   end
endmodule
